mem_b_arbiter: RTL and testbench

Shares data port B of the dual-port `memory` between two requesters:
- requester 0: the CPU data path, via `mem_addr_b`, `mem_write_data_b` and `mem_write_enable`;
- requester 1: a debug/loader master.

Grants are single-beat and issued combinationally in the request cycle. Read data comes back registered one cycle later, tagged to the owner. CPU has fixed priority; an optional starvation guard and a lock for requester 1 bursts prevent lockout. Port A (instruction fetch) is not touched.

---
 rtl/mem_b_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_b_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_b_arbiter.sv
// -----------------------------------------------------------------------------
// mem_b_arbiter
//
// Shares data port B of the dual-port memory between two requesters:
//   requester 0 : CPU data path (fixed priority)
//   requester 1 : debug / loader master (may lock the port for bursts)
//
// Grants are single-beat and combinational in the request cycle: a granted
// write is captured by the memory on the edge closing the grant cycle, and a
// granted read returns one cycle later, tagged to its owner via rvalid0/1.
//
// Optional feature (compile-time macro):
//   ARB_STARVE_EN  - starvation guard. Requester 1 is force-granted on its
//                    (MAX_WAIT+1)-th consecutive refused cycle, overriding
//                    requester 0. Undefined: strict CPU priority and no wait
//                    counter is built.
//
// Parameters:
//   AW        address width
//   DW        data width
//   MAX_WAIT  refused cycles tolerated for requester 1 (guard only, >= 1)
//
// Ports:
//   clk                  clock, all state on rising edge
//   rst                  synchronous active-high reset
//   req0/req1            request valid per requester
//   we0/we1              write (1) / read (0) per requester
//   addr0/addr1          address per requester
//   wdata0/wdata1        write data per requester
//   lock1                requester 1 holds the port while asserted with req1
//   gnt0/gnt1            combinational grant, beat completes this cycle
//   rvalid0/rvalid1      read data valid for the given owner
//   rdata                shared read data, qualified by rvalid0/rvalid1
//   addr_b/we_b/write_data_b  memory port B request
//   data_out_b           memory port B read data (valid cycle after address)
// -----------------------------------------------------------------------------
module mem_b_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] addr_b,
  output logic          we_b,
  output logic [DW-1:0] write_data_b,
  input  logic [DW-1:0] data_out_b
);

  logic       gnt0_s;
  logic       gnt1_s;
  logic       starve_s;
  logic       owner_lock_r;
  logic [1:0] rd_pend_r;   // one-hot read-owner tag: bit0 = req0, bit1 = req1

  // A zero MAX_WAIT would make the guard fire on every cycle req1 is high.
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("mem_b_arbiter: MAX_WAIT must be at least 1");
  end

`ifdef ARB_STARVE_EN
  localparam int WCW = $clog2(MAX_WAIT + 1);

  logic [WCW-1:0] wait_cnt_r;

  // Guard fires once requester 1 has been refused MAX_WAIT cycles in a row.
  assign starve_s = req1 & (wait_cnt_r == WCW'(MAX_WAIT));

  // Consecutive-refusal counter for requester 1, saturating at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= {WCW{1'b0}};
    end else if (gnt1_s || !req1) begin
      wait_cnt_r <= {WCW{1'b0}};
    end else if (wait_cnt_r != WCW'(MAX_WAIT)) begin
      wait_cnt_r <= wait_cnt_r + WCW'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end
`else
  assign starve_s = 1'b0;
`endif

  // Priority arbitration: reset, held lock, starvation guard, CPU, requester 1.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (owner_lock_r && req1) begin
      gnt1_s = 1'b1;
    end else if (starve_s) begin
      gnt1_s = 1'b1;
    end else if (req0) begin
      gnt0_s = 1'b1;
    end else if (req1) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Port B mux: follow requester 1 only when it holds the grant.
  always_comb begin
    addr_b       = addr0;
    write_data_b = wdata0;
    if (gnt1_s) begin
      addr_b       = addr1;
      write_data_b = wdata1;
    end else begin
      addr_b       = addr0;
      write_data_b = wdata0;
    end
    // Write strobe is qualified by the grant so it never fires unowned.
    we_b = (gnt0_s & we0) | (gnt1_s & we1);
  end

  // Burst lock and read-owner tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_lock_r <= 1'b0;
      rd_pend_r    <= 2'b00;
    end else begin
      rd_pend_r <= {gnt1_s & ~we1, gnt0_s & ~we0};
      if (gnt1_s && lock1) begin
        owner_lock_r <= 1'b1;
      end else if (!req1 || !lock1) begin
        owner_lock_r <= 1'b0;
      end else begin
        owner_lock_r <= owner_lock_r;
      end
    end
  end

  assign gnt0 = gnt0_s;
  assign gnt1 = gnt1_s;

  // Read return. A reset arriving while a read is outstanding suppresses the
  // pending rvalid immediately rather than letting it leak out for a cycle.
  // rdata passes the memory's registered output through only while valid.
  always_comb begin
    rvalid0 = rd_pend_r[0] & ~rst;
    rvalid1 = rd_pend_r[1] & ~rst;
    if ((rd_pend_r[0] | rd_pend_r[1]) && !rst) begin
      rdata = data_out_b;
    end else begin
      rdata = {DW{1'b0}};
    end
  end

endmodule

// File: tb/tb_mem_b_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for mem_b_arbiter. Models the memory port B, keeps a behavioural
// reference (reference memory, refusal count, burst flag, pending read) and
// compares every output on every falling edge, plus directed literal checks.
// -----------------------------------------------------------------------------
module tb_mem_b_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, we_b;
  logic [DW-1:0] rdata, write_data_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] data_out_b = '0;

  int total = 0;
  int bad   = 0;

  mem_b_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .addr_b(addr_b), .we_b(we_b), .write_data_b(write_data_b),
    .data_out_b(data_out_b)
  );

  always #5 clk = ~clk;

  // Memory port B stand-in: read-before-write, registered read data.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    data_out_b <= mem[addr_b];
    if (we_b) mem[addr_b] <= write_data_b;
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [256];
  bit            m_lock = 1'b0;
  int            m_wait = 0;
  bit [1:0]      m_pend = 2'b00;
  logic [DW-1:0] m_pend_data = '0;
  bit            m_r0_refused = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Who wins this cycle: 0 none, 1 requester 0, 2 requester 1.
  function automatic int arb(bit r, bit q0, bit q1, bit lk, int w);
    if (r) return 0;
    if (lk && q1) return 2;
`ifdef ARB_STARVE_EN
    if (q1 && w >= MAX_WAIT) return 2;
`endif
    if (q0) return 1;
    if (q1) return 2;
    return 0;
  endfunction

  // Model update on each rising edge, using the inputs of the closing cycle.
  always @(posedge clk) begin
    int g;
    g = arb(rst, req0, req1, m_lock, m_wait);
    if (rst) begin
      m_lock = 1'b0; m_wait = 0; m_pend = 2'b00; m_r0_refused = 1'b0;
    end else begin
      m_pend = 2'b00;
      if (g == 1 && !we0) begin m_pend = 2'b01; m_pend_data = ref_mem[addr0]; end
      if (g == 2 && !we1) begin m_pend = 2'b10; m_pend_data = ref_mem[addr1]; end
      if (g == 1 && we0) ref_mem[addr0] = wdata0;
      if (g == 2 && we1) ref_mem[addr1] = wdata1;
      if (g == 2 && lock1) m_lock = 1'b1;
      else if (!req1 || !lock1) m_lock = 1'b0;
      if (g == 2 || !req1) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
      m_r0_refused = req0 && (g != 1);
    end
  end

  // Compare process: every output against the model, away from the rising edge.
  always @(negedge clk) begin
    int g;
    bit [1:0] ev;
    g  = arb(rst, req0, req1, m_lock, m_wait);
    ev = rst ? 2'b00 : m_pend;
    chk("gnt0", gnt0, (g == 1));
    chk("gnt1", gnt1, (g == 2));
    chk("we_b", we_b, (g == 1 && we0) || (g == 2 && we1));
    chk("addr_b", addr_b, (g == 2) ? addr1 : addr0);
    chk("write_data_b", write_data_b, (g == 2) ? wdata1 : wdata0);
    chk("rvalid0", rvalid0, ev[0]);
    chk("rvalid1", rvalid1, ev[1]);
    if (ev != 2'b00) chk("rdata", rdata, m_pend_data);
    else if (rst) chk("rdata_rst", rdata, 8'h00);
  end

  task automatic idle();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int n1;
    // Reset with both requesting.
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_gnt0", gnt0, 1'b0);
      chk("rst_gnt1", gnt1, 1'b0);
      chk("rst_we_b", we_b, 1'b0);
      chk("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
      step();
    end
    rst = 1'b0; idle(); step();

    // Requester 0 write then read.
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hA5;
    @(negedge clk); chk("wr_gnt0", gnt0, 1'b1); step();
    we0 = 1'b0;
    @(negedge clk); chk("rd_gnt0", gnt0, 1'b1); step();
    idle();
    @(negedge clk);
    chk("rd_rvalid0", rvalid0, 1'b1);
    chk("rd_rvalid1", rvalid1, 1'b0);
    chk("rd_rdata", rdata, 8'hA5);
    step(); step();

    // Contention: both reading continuously.
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h10; addr1 = 8'h11;
    n1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
`ifdef ARB_STARVE_EN
      chk("cont_gnt1", gnt1, (i == 4 || i == 9));
`else
      chk("cont_gnt0", gnt0, 1'b1);
`endif
      if (gnt1) n1++;
      step();
    end
`ifdef ARB_STARVE_EN
    chk("cont_n1", n1, 2);
`else
    chk("cont_n1", n1, 0);
`endif
    idle(); step();

    // Lock burst: requester 1 writes 0x20..0x23 while the CPU waits.
    for (int i = 0; i < 4; i++) begin
      req1 = 1'b1; lock1 = 1'b1; we1 = 1'b1; addr1 = 8'h20 + 8'(i); wdata1 = 8'h50 + 8'(i);
      req0 = (i != 0); we0 = 1'b0; addr0 = 8'h10;
      @(negedge clk);
      chk("lock_gnt1", gnt1, 1'b1);
      chk("lock_gnt0", gnt0, 1'b0);
      step();
    end
    req1 = 1'b0; lock1 = 1'b0; we1 = 1'b0;
    @(negedge clk); chk("unlock_gnt0", gnt0, 1'b1); step();
    idle(); step();

    // Back-to-back reads with interleaved owners.
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h01; wdata0 = 8'h11; step();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 8'h02; wdata1 = 8'h22; step();
    req1 = 1'b0; we1 = 1'b0; req0 = 1'b1; we0 = 1'b0; step();
    req0 = 1'b0; req1 = 1'b1;
    @(negedge clk);
    chk("b2b_gnt1", gnt1, 1'b1);
    chk("b2b_rvalid0", rvalid0, 1'b1);
    chk("b2b_rdata0", rdata, 8'h11);
    step();
    idle();
    @(negedge clk);
    chk("b2b_rvalid1", rvalid1, 1'b1);
    chk("b2b_rdata1", rdata, 8'h22);
    step();

    // Reset while a read is pending.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01; step();
    idle(); rst = 1'b1;
    @(negedge clk); chk("rstrd_rvalid0", rvalid0, 1'b0); step();
    rst = 1'b0;
    @(negedge clk); chk("rstrd_rvalid0_after", rvalid0, 1'b0); step();
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk); chk("rstrd_gnt0", gnt0, 1'b1); step();
    idle(); step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!m_r0_refused) begin
        req0   = ($urandom_range(0, 99) < 55);
        we0    = $urandom_range(0, 1);
        addr0  = 8'($urandom_range(0, 15));
        wdata0 = 8'($urandom);
      end
      req1   = ($urandom_range(0, 99) < 60);
      we1    = $urandom_range(0, 1);
      lock1  = ($urandom_range(0, 99) < 40);
      addr1  = 8'($urandom_range(0, 15));
      wdata1 = 8'($urandom);
      step();
    end
    rst = 1'b0; idle(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
